fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the scalar core, directly upstream of the instruction buffer. Generates sequential fetch addresses, issues them to the instruction memory/I-cache over a valid/ready request channel, and receives in-order responses. Tags each response with its PC and presents it to the instruction buffer over a valid/ready channel. On a flush it redirects to a new PC and silently discards every response still in flight from the old path. Credit-based issue guarantees every response has a slot, so the response channel has no back-pressure.

## Interface
Parameters:
- DW, 64, fetch word width in bits; bytes per fetch = DW/8 (power of two)
- AW, 32, address width
- MAX_OUT, 4, max requests in flight plus buffered responses; also the local queue depth
- BOOT_PC, 32'h8000_0000, first fetch address after reset (DW/8-aligned)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  redirect request, single-cycle pulse
- flush_pc_i  in  AW  redirect target; low log2(DW/8) bits ignored
- mem_req_valid_o  out  1  fetch request valid
- mem_req_addr_o  out  AW  fetch address, DW/8-aligned
- mem_req_ready_i  in  1  memory accepts request
- mem_rsp_valid_i  in  1  response valid; always accepted
- mem_rsp_data_i  in  DW  response data
- data_o  out  DW  fetched word to instruction buffer
- pc_o  out  AW  address of data_o
- valid_o  out  1  data_o/pc_o valid
- ready_i  in  1  instruction buffer accepts

## Operation
- State:
  - req_pc: next address to request.
  - rsp_pc: PC of the next non-stale response.
  - out_cnt: requests accepted but not yet answered, stale ones included.
  - drop_cnt: stale responses still to discard; always <= out_cnt.
  - Queue: MAX_OUT entries of {pc, data} with q_cnt; counters $clog2(MAX_OUT+1) bits.
- Issue: mem_req_valid_o = !flush_i && (out_cnt + q_cnt < MAX_OUT); mem_req_addr_o = req_pc.
  - On accept (valid & ready): req_pc += DW/8, out_cnt++.
  - Address/valid are held stable until accepted, except that flush_i withdraws the request.
- Response: each mem_rsp_valid_i does out_cnt--.
  - If drop_cnt > 0, or flush_i is high in that cycle: discard; drop_cnt-- (flush case handled below).
  - Otherwise: push {rsp_pc, mem_rsp_data_i} into the queue; rsp_pc += DW/8.
- Output: head of queue; valid_o = (q_cnt != 0) && !flush_i; pop on valid_o & ready_i.
  - Push and pop in the same cycle leave q_cnt unchanged.
- Flush, in the cycle flush_i = 1:
  - No request is issued.
  - Queue is emptied.
  - req_pc and rsp_pc := flush_pc_i with low bits cleared.
  - drop_cnt := out_cnt - mem_rsp_valid_i.
  - Any response arriving that cycle is discarded.
  - Issue resumes the next cycle.
- Address arithmetic wraps modulo 2^AW.
- Response with out_cnt == 0 is a protocol violation: ignored; simulation assertion fires.

## Timing
- Reset (async assert): req_pc = rsp_pc = BOOT_PC; out_cnt = drop_cnt = q_cnt = 0.
  - Outputs during reset: mem_req_valid_o = 0, valid_o = 0; data_o/pc_o don't-care.
  - mem_req_addr_o = BOOT_PC.
- First cycle after rst_n deasserts: mem_req_valid_o = 1, addr = BOOT_PC.
- Back-to-back issue: one request per cycle while credits remain.
- Response in cycle N -> valid_o in cycle N+1 (registered queue, no bypass).
- Credit stall: issue stops once out_cnt + q_cnt == MAX_OUT; a pop or a stale drop frees one credit, usable the next cycle.
- The queue can never overflow.
- First new-path request: cycle after flush_i.
- First new-path response reaching the output needs drop_cnt to drain first.
- Flush concurrent with a request accept or a pop: flush wins; no accept, no pop.
- Reset asserted mid-operation: all counters clear immediately; in-flight responses after reset are not expected.

## Test plan
- Reset then free-running, mem ready=1, 1-cycle response latency, ready_i=1 -> requests 0x8000_0000, 0x8000_0008, 0x8000_0010…; valid_o on consecutive cycles with matching pc_o/data_o.
- ready_i=0 for 20 cycles, memory ready -> exactly 4 requests issued, queue fills to 4, no further issue; then ready_i=1 -> 4 pops and issue resumes at 0x8000_0020.
- 3 requests outstanding, flush_i with flush_pc_i=0x8000_1004 -> next request 0x8000_1000; 3 old responses dropped; first valid_o has pc_o=0x8000_1000.
- Flush coincident with an arriving response and a pending pop -> that response is dropped, drop_cnt = out_cnt-1, queue empty, valid_o low that cycle.
- BOOT_PC=32'hFFFF_FFF8 -> second request address 0x0000_0000.
- mem_req_ready_i toggling randomly -> mem_req_addr_o stable while valid and not accepted, and no address is skipped or repeated.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage that sits directly upstream of the instruction
// buffer.
//   - Generates sequential, DW/8-aligned fetch addresses and issues them over
//     a valid/ready request channel.
//   - Receives in-order responses, tags each one with its PC, and buffers it in
//     a MAX_OUT-deep queue that drives the instruction buffer.
//   - On a flush, redirects both PCs and silently drops every response still
//     in flight from the old path.
//   - Credit-based issue (requests in flight + buffered words <= MAX_OUT)
//     guarantees every response has a slot, so the response channel has no
//     back-pressure.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush_i, flush_pc_i redirect pulse and target (low log2(DW/8) bits ignored)
//   mem_req_*           fetch request channel (valid/ready, aligned address)
//   mem_rsp_*           fetch response channel (always accepted)
//   data_o, pc_o        fetched word and its address
//   valid_o, ready_i    handshake toward the instruction buffer
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned    DW      = 64,
  parameter int unsigned    AW      = 32,
  parameter int unsigned    MAX_OUT = 4,
  parameter logic [AW-1:0]  BOOT_PC = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic [AW-1:0] flush_pc_i,
  output logic          mem_req_valid_o,
  output logic [AW-1:0] mem_req_addr_o,
  input  logic          mem_req_ready_i,
  input  logic          mem_rsp_valid_i,
  input  logic [DW-1:0] mem_rsp_data_i,
  output logic [DW-1:0] data_o,
  output logic [AW-1:0] pc_o,
  output logic          valid_o,
  input  logic          ready_i
);

  localparam int unsigned   BYTES      = DW / 8;
  localparam int unsigned   CW         = $clog2(MAX_OUT + 1);
  localparam int unsigned   PW         = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [AW-1:0] STEP       = AW'(BYTES);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BYTES - 1);

  // Architectural state
  logic [AW-1:0] req_pc;    // next address to request
  logic [AW-1:0] rsp_pc;    // PC of the next non-stale response
  logic [CW-1:0] out_cnt;   // accepted requests not yet answered (stale included)
  logic [CW-1:0] drop_cnt;  // stale responses still to discard
  logic [CW-1:0] q_cnt;     // words held in the output queue

  // Output queue (circular buffer)
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [AW-1:0] q_pc   [MAX_OUT];
  logic [DW-1:0] q_data [MAX_OUT];

  logic [CW:0]   in_use;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_drop;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits: a slot is reserved in the queue for every request in flight.
  assign in_use    = {1'b0, out_cnt} + {1'b0, q_cnt};
  assign credit_ok = in_use < (CW + 1)'(MAX_OUT);

  // NOTE: request valid is gated by rst_n so that it reads low while reset is
  // held, yet rises in the very first cycle after release without waiting for
  // a clock edge.
  assign mem_req_valid_o = rst_n & ~flush_i & credit_ok;
  assign mem_req_addr_o  = req_pc;

  assign req_fire = mem_req_valid_o & mem_req_ready_i;
  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_take = mem_rsp_valid_i & (out_cnt != '0);
  assign rsp_drop = flush_i | (drop_cnt != '0);
  assign push     = rsp_take & ~rsp_drop;

  assign valid_o  = (q_cnt != '0) & ~flush_i;
  assign pop      = valid_o & ready_i;
  assign data_o   = q_data[rd_ptr];
  assign pc_o     = q_pc[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc   <= BOOT_PC;
      rsp_pc   <= BOOT_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      q_cnt    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      // Flush suppresses the request, so out_cnt never counts a new-path
      // request in the same cycle as a redirect.
      out_cnt <= out_cnt + CW'(req_fire) - CW'(rsp_take);
      if (flush_i) begin
        req_pc   <= flush_pc_i & ALIGN_MASK;
        rsp_pc   <= flush_pc_i & ALIGN_MASK;
        // Everything still outstanding after this cycle belongs to the old path.
        drop_cnt <= out_cnt - CW'(rsp_take);
        q_cnt    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) begin
          req_pc <= req_pc + STEP;
        end
        if (rsp_take && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          rsp_pc <= rsp_pc + STEP;
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        q_cnt <= q_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: queue storage has no reset; q_cnt alone says which entries are live,
  // so clearing the payload would only cost flops.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= rsp_pc;
      q_data[wr_ptr] <= mem_rsp_data_i;
    end
  end

  a_rsp_has_request : assert property (
    @(posedge clk) disable iff (!rst_n) mem_rsp_valid_i |-> (out_cnt != '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Randomized bench for fetch_unit.
//   - Memory: an in-order memory with random latency and random accept. Each
//     word returned is a fixed function of its address.
//   - Reference model: expressed in terms of paths (epochs):
//       * requests are expected at consecutive aligned addresses from the last
//         redirect;
//       * responses belonging to an older epoch never appear;
//       * issue is allowed while requests in flight plus words waiting for the
//         instruction buffer stay below MAX_OUT.
//   - Checking: the driver pushes the expected {pc, data} into a scoreboard
//     queue when a request is accepted. A separate monitor pops and compares
//     whenever the DUT hands a word over.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          DW      = 64;
  localparam int          AW      = 32;
  localparam int          MAX_OUT = 4;
  localparam logic [31:0] BOOT_PC = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i;
  logic [AW-1:0] flush_pc_i;
  logic          mem_req_valid_o;
  logic [AW-1:0] mem_req_addr_o;
  logic          mem_req_ready_i;
  logic          mem_rsp_valid_i;
  logic [DW-1:0] mem_rsp_data_i;
  logic [DW-1:0] data_o;
  logic [AW-1:0] pc_o;
  logic          valid_o;
  logic          ready_i;

  fetch_unit #(
    .DW(DW), .AW(AW), .MAX_OUT(MAX_OUT), .BOOT_PC(BOOT_PC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .data_o          (data_o),
    .pc_o            (pc_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          rdy;   // earliest cycle the memory may answer
    int          ep;    // path the request belongs to
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] data;
  } item_t;

  mreq_t mem_pend[$];   // requests accepted by the memory, not yet answered
  item_t exp_q[$];      // current-path words not yet handed to the buffer

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          epoch    = 0;
  int          q_model  = 0;   // current-path words sitting in the DUT queue
  int          n_combo  = 0;
  logic [31:0] exp_req_pc;
  bit          mon_en   = 1'b0;

  // Stimulus knobs
  int          p_mreq, p_rdy, p_rsp, lat_extra, p_flush;
  bit          combo;
  bit          force_flush = 1'b0;
  logic [31:0] force_pc;

  function automatic logic [63:0] word_of(input logic [31:0] a);
    return {a ^ 32'h5A5A_C3C3, ~a + 32'h0000_1357};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: consumes the scoreboard whenever the DUT transfers a word.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output_pc", {32'h0, pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", {32'h0, pc_o}, {32'h0, e.pc});
          check("out_data", data_o, e.data);
        end
      end
    end
  end

  // One clock of stimulus plus model update.
  task automatic step();
    bit    rsp_now, rsp_cur, exp_rv, exp_vo, pop;
    mreq_t r;
    @(negedge clk);
    cyc++;
    // NOTE: inputs are driven with blocking assignments at the falling edge,
    // half a cycle clear of the edge that samples them.
    mem_req_ready_i = ($urandom_range(99) < p_mreq);
    ready_i         = ($urandom_range(99) < p_rdy);
    rsp_now = (mem_pend.size() != 0) && (mem_pend[0].rdy <= cyc) &&
              ($urandom_range(99) < p_rsp);
    mem_rsp_valid_i = rsp_now;
    mem_rsp_data_i  = rsp_now ? word_of(mem_pend[0].addr) : {$urandom, $urandom};
    flush_i = force_flush || ($urandom_range(999) < p_flush) ||
              (combo && rsp_now && q_model != 0 && ready_i && $urandom_range(3) == 0);
    if (force_flush) flush_pc_i = force_pc;
    else if ($urandom_range(3) == 0) flush_pc_i = 32'hFFFF_FFE0 | 32'($urandom_range(31));
    else flush_pc_i = $urandom;
    if (flush_i && rsp_now && q_model != 0 && ready_i) n_combo++;
    force_flush = 1'b0;
    #1;
    exp_rv = !flush_i && (mem_pend.size() + q_model < MAX_OUT);
    exp_vo = !flush_i && (q_model != 0);
    check("req_valid", {63'h0, mem_req_valid_o}, {63'h0, exp_rv});
    if (mem_req_valid_o) check("req_addr", {32'h0, mem_req_addr_o}, {32'h0, exp_req_pc});
    check("valid_o", {63'h0, valid_o}, {63'h0, exp_vo});

    pop     = exp_vo && ready_i;
    rsp_cur = 1'b0;
    if (rsp_now) begin
      r = mem_pend.pop_front();
      rsp_cur = (r.ep == epoch) && !flush_i;
    end
    if (flush_i) begin
      // Redirect: every older request becomes stale and the queue is emptied.
      epoch++;
      exp_req_pc = flush_pc_i & ~32'h7;
      q_model    = 0;
      exp_q.delete();
    end else begin
      q_model = q_model + int'(rsp_cur) - int'(pop);
      if (exp_rv && mem_req_ready_i) begin
        mem_pend.push_back('{exp_req_pc, cyc + 1 + $urandom_range(lat_extra), epoch});
        exp_q.push_back('{exp_req_pc, word_of(exp_req_pc)});
        exp_req_pc = exp_req_pc + 32'd8;
      end
    end
  endtask

  task automatic run(input int n, input int mreq, input int rdy, input int rsp,
                     input int lat, input int pfl, input bit cmb);
    p_mreq = mreq; p_rdy = rdy; p_rsp = rsp; lat_extra = lat;
    p_flush = pfl; combo = cmb;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en          = 1'b0;
    rst_n           = 1'b0;
    flush_i         = 1'b0;
    flush_pc_i      = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    ready_i         = 1'b0;
    #1;
    check("rst_req_valid", {63'h0, mem_req_valid_o}, 64'h0);
    check("rst_valid_o", {63'h0, valid_o}, 64'h0);
    check("rst_req_addr", {32'h0, mem_req_addr_o}, {32'h0, BOOT_PC});
    mem_pend.delete();
    exp_q.delete();
    q_model    = 0;
    epoch++;
    exp_req_pc = BOOT_PC;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    #1;
    check("post_rst_req_valid", {63'h0, mem_req_valid_o}, 64'h1);
    check("post_rst_req_addr", {32'h0, mem_req_addr_o}, {32'h0, BOOT_PC});
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset();

    // Free running, 1-cycle memory latency.
    run(30, 100, 100, 100, 0, 0, 1'b0);
    // Instruction buffer stalled: credits must cap issue.
    run(20, 100, 0, 100, 0, 0, 1'b0);
    check("stall_no_issue", {63'h0, mem_req_valid_o}, 64'h0);
    run(10, 100, 100, 100, 0, 0, 1'b0);

    // Redirect with requests outstanding and no responses yet.
    run(3, 100, 100, 0, 0, 0, 1'b0);
    force_pc = 32'h8000_1004; force_flush = 1'b1;
    run(1, 100, 100, 0, 0, 0, 1'b0);
    run(20, 100, 100, 100, 2, 0, 1'b0);

    // Redirect near the top of the address space: addresses wrap to zero.
    force_pc = 32'hFFFF_FFF8; force_flush = 1'b1;
    run(1, 100, 100, 100, 0, 0, 1'b0);
    run(20, 100, 100, 100, 1, 0, 1'b0);

    // Flushes landing on a cycle with an arriving response and a pending pop.
    run(400, 100, 80, 80, 2, 0, 1'b1);
    // Fully random handshakes and occasional redirects.
    run(3000, 60, 60, 70, 3, 15, 1'b0);

    // Reset in the middle of traffic.
    do_reset();
    run(300, 70, 70, 70, 2, 10, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
